qkt_row_scheduler: RTL and testbench
====================================

Name: qkt_row_scheduler

Overview:
Sequences the fused QK^T-softmax engine (qkt_softmax) across multiple query rows. Accepts one command per batch with the query count and key count. Starts the engine once per row and maps the engine's dk_idx/key_idx onto flat Q and K buffer addresses. Writes each row's softmax outputs into a result buffer at row*num_keys + softmax_idx.

Parameters:
D_K, 64, key dimension; even power of 2, equal to the engine's D_K
MAX_Q, 128, maximum query rows per command
MAX_K, 128, maximum keys per row; equal to the engine's MAX_NUM_QUERIES
SOFTMAX_OUT_WIDTH, 12, engine softmax output width
IDX_W, 11, width of the engine index ports

Ports:
clk  in  1  clock
rst_  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_num_q  in  8  query rows, 1..MAX_Q
cmd_num_k  in  9  keys per row, 1..MAX_K
abort  in  1  abandon the batch
busy  out  1  high when state != IDLE
batch_done  out  1  1-cycle pulse at batch end
err  out  1  sticky error flag; cleared on accepted command
eng_start  out  1  1-cycle start pulse to the engine
eng_num_keys  out  9  drives the engine's num_queries port
eng_dk_idx, eng_key_idx, eng_softmax_idx  in  IDX_W  engine indices
eng_softmax_j  in  SOFTMAX_OUT_WIDTH  engine softmax output
eng_valid_out, eng_done  in  1  engine status
q_addr  out  clog2(MAX_Q*D_K)  equals row*D_K + eng_dk_idx (combinational); read is asynchronous
k_addr  out  clog2(MAX_K*D_K)  equals eng_key_idx*D_K + eng_dk_idx (combinational)
res_we  out  1  result write enable
res_addr  out  clog2(MAX_Q*MAX_K)  result write address
res_data  out  SOFTMAX_OUT_WIDTH  result write data

Behaviour:
- Clock and reset: single clk; reset is synchronous and active-low on rst_.
- Reset values: state=IDLE, cmd_ready=1, busy=0, batch_done=0, err=0, eng_start=0, res_we=0, res_addr=0, res_data=0, row=0, wr_cnt=0.
- Command acceptance: in IDLE, cmd_valid&&cmd_ready latches num_q and num_k and clears err.
  - num_q==0, num_k==0, num_q>MAX_Q or num_k>MAX_K: set err=1, pulse batch_done the next cycle, stay IDLE.
- States:
  - IDLE -> START on a legal command.
  - START: eng_start=1 for exactly one cycle; wr_cnt=0; -> RUN.
  - RUN: on eng_valid_out, register one write in the next cycle: res_we=1, res_addr=row*num_k+eng_softmax_idx, res_data=eng_softmax_j; wr_cnt++. Write latency is 1 cycle.
  - RUN -> ROW_END on eng_done. A valid_out in the same cycle as done is still written.
  - ROW_END: if wr_cnt!=num_k, set err=1. If row==num_q-1 -> FINISH, else row++ -> START.
  - FINISH: batch_done=1 for one cycle; -> IDLE.
- eng_num_keys holds the latched num_k from acceptance until the next command.
- Out-of-range index: eng_valid_out with eng_softmax_idx>=num_k sets err=1 and suppresses that write.
- abort (any non-IDLE state): -> FINISH next cycle; no further eng_start or res_we. Any write registered in the abort cycle still completes.
- Reset mid-batch returns all state to reset values. The engine is reset from the same rst_.
- q_addr and k_addr are pure functions of the current row and the engine indices; address arithmetic is unsigned with no wrap.

Decomposition:
- Package qkt_sched_pkg: state enum (IDLE, START, RUN, ROW_END, FINISH), address-width localparams from clog2, and a result-write struct {we, addr, data}.
- One sub-module, qkt_addr_gen: combinational q_addr/k_addr/res_addr generation (multiplies by D_K implemented as shifts).

Test Plan:
- Command num_q=3, num_k=64 with the real engine attached -> 3 eng_start pulses, 192 res_we writes to addresses 0..191 each exactly once, one batch_done, err=0.
- num_q=1, num_k=1 -> single write to address 0, batch_done, err=0.
- num_q=0 -> cmd accepted, batch_done one cycle later, err=1, no eng_start.
- Engine model emits only 63 valid_out for num_k=64 -> err=1 at ROW_END; the batch still completes.
- abort asserted mid-row 1 of 4 -> no further eng_start or res_we after the abort cycle, batch_done pulse, busy=0, cmd_ready=1.
- rst_ low for one cycle during RUN -> all outputs at reset values on the next edge; a following command runs cleanly.

Source files
------------

// File: rtl/qkt_sched_pkg.sv
// Shared geometry, state encoding and result-write record for the QK^T row scheduler.
// Widths are derived here so every file agrees on address sizes.
package qkt_sched_pkg;

    localparam int D_K               = 64;
    localparam int MAX_Q             = 128;
    localparam int MAX_K             = 128;
    localparam int SOFTMAX_OUT_WIDTH = 12;
    localparam int IDX_W             = 11;

    localparam int NUM_Q_W    = 8;
    localparam int NUM_K_W    = 9;
    localparam int DK_SHIFT   = $clog2(D_K);
    localparam int ROW_W      = $clog2(MAX_Q);
    localparam int Q_ADDR_W   = $clog2(MAX_Q * D_K);
    localparam int K_ADDR_W   = $clog2(MAX_K * D_K);
    localparam int RES_ADDR_W = $clog2(MAX_Q * MAX_K);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        ROW_END,
        FINISH
    } state_t;

    typedef struct packed {
        logic                         we;
        logic [RES_ADDR_W-1:0]        addr;
        logic [SOFTMAX_OUT_WIDTH-1:0] data;
    } res_wr_t;

    // A batch needs at least one row and one key, and must fit the buffers.
    function automatic logic cmd_is_legal(input logic [NUM_Q_W-1:0] nq,
                                          input logic [NUM_K_W-1:0] nk);
        return (nq != '0) && (nq <= NUM_Q_W'(MAX_Q)) &&
               (nk != '0) && (nk <= NUM_K_W'(MAX_K));
    endfunction

endpackage

// File: rtl/qkt_addr_gen.sv
// Combinational address generation for the Q, K and result buffers.
// D_K is a power of two, so the D_K multiplies are plain shifts.
module qkt_addr_gen
    import qkt_sched_pkg::*;
(
    input  logic [ROW_W-1:0]      row,
    input  logic [NUM_K_W-1:0]    num_k,
    input  logic [IDX_W-1:0]      dk_idx,
    input  logic [IDX_W-1:0]      key_idx,
    input  logic [IDX_W-1:0]      softmax_idx,
    output logic [Q_ADDR_W-1:0]   q_addr,
    output logic [K_ADDR_W-1:0]   k_addr,
    output logic [RES_ADDR_W-1:0] res_addr
);

    localparam int RW = ROW_W + NUM_K_W + 1;

    logic [RW-1:0] res_wide;

    assign q_addr = Q_ADDR_W'({row, DK_SHIFT'(0)}) + Q_ADDR_W'(dk_idx);
    assign k_addr = K_ADDR_W'({key_idx, DK_SHIFT'(0)}) + K_ADDR_W'(dk_idx);

    // Row base needs a true multiply since num_k is not a power of two.
    assign res_wide = RW'(row) * RW'(num_k) + RW'(softmax_idx);
    assign res_addr = RES_ADDR_W'(res_wide);

endmodule

// File: rtl/qkt_row_scheduler.sv
// Runs the fused QK^T-softmax engine once per query row and scatters each
// row's softmax outputs into the flat result buffer.
module qkt_row_scheduler
    import qkt_sched_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [NUM_Q_W-1:0]           cmd_num_q,
    input  logic [NUM_K_W-1:0]           cmd_num_k,
    input  logic                         abort,
    output logic                         busy,
    output logic                         batch_done,
    output logic                         err,
    output logic                         eng_start,
    output logic [NUM_K_W-1:0]           eng_num_keys,
    input  logic [IDX_W-1:0]             eng_dk_idx,
    input  logic [IDX_W-1:0]             eng_key_idx,
    input  logic [IDX_W-1:0]             eng_softmax_idx,
    input  logic [SOFTMAX_OUT_WIDTH-1:0] eng_softmax_j,
    input  logic                         eng_valid_out,
    input  logic                         eng_done,
    output logic [Q_ADDR_W-1:0]          q_addr,
    output logic [K_ADDR_W-1:0]          k_addr,
    output logic                         res_we,
    output logic [RES_ADDR_W-1:0]        res_addr,
    output logic [SOFTMAX_OUT_WIDTH-1:0] res_data
);

    state_t                state;
    logic [ROW_W-1:0]      row;
    logic [NUM_Q_W-1:0]    num_q;
    logic [NUM_K_W-1:0]    num_k;
    logic [NUM_K_W-1:0]    wr_cnt;
    res_wr_t               wr;
    logic [RES_ADDR_W-1:0] res_addr_calc;
    logic                  idx_in_range;
    logic                  last_row;

    qkt_addr_gen u_addr_gen (
        .row         (row),
        .num_k       (num_k),
        .dk_idx      (eng_dk_idx),
        .key_idx     (eng_key_idx),
        .softmax_idx (eng_softmax_idx),
        .q_addr      (q_addr),
        .k_addr      (k_addr),
        .res_addr    (res_addr_calc)
    );

    assign idx_in_range = eng_softmax_idx < IDX_W'(num_k);
    assign last_row     = NUM_Q_W'(row) == (num_q - NUM_Q_W'(1));

    assign eng_num_keys = num_k;
    assign res_we       = wr.we;
    assign res_addr     = wr.addr;
    assign res_data     = wr.data;

    // Pulses (eng_start, batch_done, res_we) default low and are raised on the
    // edge that enters the state they belong to, so each lasts one cycle.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            batch_done <= 1'b0;
            err        <= 1'b0;
            eng_start  <= 1'b0;
            wr         <= '0;
            row        <= '0;
            wr_cnt     <= '0;
            num_q      <= '0;
            num_k      <= '0;
        end else begin
            eng_start  <= 1'b0;
            batch_done <= 1'b0;
            wr.we      <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        num_q <= cmd_num_q;
                        num_k <= cmd_num_k;
                        row   <= '0;
                        err   <= 1'b0;
                        if (cmd_is_legal(cmd_num_q, cmd_num_k)) begin
                            state     <= START;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            eng_start <= 1'b1;
                        end else begin
                            err        <= 1'b1;
                            batch_done <= 1'b1;
                        end
                    end
                end

                START: begin
                    wr_cnt <= '0;
                    state  <= RUN;
                end

                // A valid_out arriving together with done is still captured.
                RUN: begin
                    if (eng_valid_out && !abort) begin
                        if (idx_in_range) begin
                            wr     <= '{we: 1'b1, addr: res_addr_calc, data: eng_softmax_j};
                            wr_cnt <= wr_cnt + NUM_K_W'(1);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    if (eng_done) begin
                        state <= ROW_END;
                    end
                end

                ROW_END: begin
                    if (wr_cnt != num_k) begin
                        err <= 1'b1;
                    end
                    if (last_row) begin
                        state      <= FINISH;
                        batch_done <= 1'b1;
                    end else begin
                        row       <= row + ROW_W'(1);
                        state     <= START;
                        eng_start <= 1'b1;
                    end
                end

                FINISH: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase

            // Abort overrides whatever the active state chose; a write already
            // on the result port this cycle is left to complete.
            if (abort && (state inside {START, RUN, ROW_END})) begin
                state      <= FINISH;
                batch_done <= 1'b1;
                eng_start  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qkt_row_scheduler.sv
// Randomised bench: a behavioural engine model feeds the scheduler while a
// scoreboard checks every result write, buffer address and batch outcome.
module tb_qkt_row_scheduler;

    logic        clk = 1'b0;
    logic        tb_rst = 1'b1;
    logic        eng_rst = 1'b0;
    logic        rst_;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_num_q = '0;
    logic [8:0]  cmd_num_k = '0;
    logic        abort = 1'b0;
    logic        busy, batch_done, err, eng_start;
    logic [8:0]  eng_num_keys;
    logic [10:0] eng_dk_idx = '0, eng_key_idx = '0, eng_softmax_idx = '0;
    logic [11:0] eng_softmax_j = '0;
    logic        eng_valid_out = 1'b0, eng_done = 1'b0;
    logic [12:0] q_addr, k_addr;
    logic        res_we;
    logic [13:0] res_addr;
    logic [11:0] res_data;

    assign rst_ = ~(tb_rst | eng_rst);

    always #5 clk = ~clk;

    qkt_row_scheduler dut (
        .clk             (clk),
        .rst_            (rst_),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_num_q       (cmd_num_q),
        .cmd_num_k       (cmd_num_k),
        .abort           (abort),
        .busy            (busy),
        .batch_done      (batch_done),
        .err             (err),
        .eng_start       (eng_start),
        .eng_num_keys    (eng_num_keys),
        .eng_dk_idx      (eng_dk_idx),
        .eng_key_idx     (eng_key_idx),
        .eng_softmax_idx (eng_softmax_idx),
        .eng_softmax_j   (eng_softmax_j),
        .eng_valid_out   (eng_valid_out),
        .eng_done        (eng_done),
        .q_addr          (q_addr),
        .k_addr          (k_addr),
        .res_we          (res_we),
        .res_addr        (res_addr),
        .res_data        (res_data)
    );

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t sb[$];
    bit   hit[16384];
    int   n_tests = 0, n_fail = 0;
    int   starts_seen = 0, writes_seen = 0, pushed_cnt = 0;
    int   row_count = 0, cur_row = 0;
    bit   eng_active = 1'b0, reset_fired = 1'b0;
    int   cfg_nk = 1, cfg_drop_row = -1, cfg_oor_row = -1;
    int   cfg_abort_row = -1, cfg_abort_after = 0, cfg_reset_row = -1, cfg_reset_after = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive_cycle(input bit v, input int idx, input int j, input bit d);
        eng_valid_out   = v;
        eng_softmax_idx = 11'(idx);
        eng_softmax_j   = 12'(j);
        eng_done        = d;
        eng_dk_idx      = 11'($urandom_range(0, 63));
        eng_key_idx     = 11'($urandom_range(0, 127));
        @(negedge clk);
    endtask

    // Engine model: emits every key index of the row once in random order.
    task automatic run_row();
        int  order[$];
        int  n_emit, k, j, tmp, r;
        bit  d, done_sent;
        done_sent = 1'b0;
        cur_row = row_count;
        row_count++;
        eng_active = 1'b1;
        for (int i = 0; i < cfg_nk; i++) order.push_back(i);
        for (int i = cfg_nk - 1; i > 0; i--) begin
            r = $urandom_range(0, i);
            tmp = order[i]; order[i] = order[r]; order[r] = tmp;
        end
        n_emit = cfg_nk - ((cur_row == cfg_drop_row) ? 1 : 0);
        drive_cycle(1'b0, 0, 0, 1'b0);
        for (int i = 0; i < n_emit; i++) begin
            repeat ($urandom_range(0, 2)) drive_cycle(1'b0, 0, 0, 1'b0);
            if (cur_row == cfg_abort_row && i == cfg_abort_after) begin
                abort = 1'b1;
                drive_cycle(1'b0, 0, 0, 1'b0);
                abort = 1'b0;
                eng_active = 1'b0;
                return;
            end
            if (cur_row == cfg_reset_row && i == cfg_reset_after) begin
                eng_rst = 1'b1;
                drive_cycle(1'b0, 0, 0, 1'b0);
                eng_rst = 1'b0;
                eng_active = 1'b0;
                reset_fired = 1'b1;
                return;
            end
            if (cur_row == cfg_oor_row && i == 0)
                drive_cycle(1'b1, cfg_nk + int'($urandom_range(0, 100)), int'($urandom_range(0, 4095)), 1'b0);
            k = order[i];
            j = int'($urandom_range(0, 4095));
            sb.push_back('{cur_row * cfg_nk + k, j});
            pushed_cnt++;
            d = (i == n_emit - 1) && ($urandom_range(0, 1) == 1);
            drive_cycle(1'b1, k, j, d);
            if (d) done_sent = 1'b1;
        end
        if (!done_sent) drive_cycle(1'b0, 0, 0, 1'b1);
        eng_valid_out = 1'b0;
        eng_done = 1'b0;
        eng_active = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1) run_row();
        end
    end

    // Monitor: pops the scoreboard on every result write and checks the
    // combinational buffer addresses while a row is in flight.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (eng_start === 1'b1) starts_seen++;
            if (res_we === 1'b1) begin
                writes_seen++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_write: addr %0d data %0d, required no write", res_addr, res_data);
                end else begin
                    e = sb.pop_front();
                    check_output("res_addr", 32'(res_addr), e.addr);
                    check_output("res_data", 32'(res_data), e.data);
                    check_output("res_addr_unique", 32'(hit[res_addr]), 0);
                    hit[res_addr] = 1'b1;
                end
            end
            if (eng_active) begin
                check_output("q_addr", 32'(q_addr), cur_row * 64 + int'(eng_dk_idx));
                check_output("k_addr", 32'(k_addr), int'(eng_key_idx) * 64 + int'(eng_dk_idx));
            end
        end
    end

    task automatic apply_stimulus(input int nq, input int nk, input int dr, input int oo,
                                  input int ar, input int aa, input int rr, input int ra);
        bit legal, ended, exp_err;
        int exp_starts, budget, missing;
        legal = (nq >= 1) && (nq <= 128) && (nk >= 1) && (nk <= 128);
        cfg_nk = nk; cfg_drop_row = dr; cfg_oor_row = oo;
        cfg_abort_row = ar; cfg_abort_after = aa; cfg_reset_row = rr; cfg_reset_after = ra;
        row_count = 0; starts_seen = 0; writes_seen = 0; pushed_cnt = 0; reset_fired = 1'b0;
        foreach (hit[a]) hit[a] = 1'b0;

        check_output("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_num_q = 8'(nq);
        cmd_num_k = 9'(nk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_output("err_after_accept", 32'(err), legal ? 0 : 1);
        check_output("eng_num_keys", 32'(eng_num_keys), 32'(9'(nk)));

        if (!legal) begin
            check_output("bad_cmd_done_pulse", 32'(batch_done), 1);
            check_output("bad_cmd_no_start", 32'(eng_start), 0);
            check_output("bad_cmd_busy", 32'(busy), 0);
            @(negedge clk);
            check_output("bad_cmd_done_once", 32'(batch_done), 0);
            check_output("bad_cmd_err_sticky", 32'(err), 1);
            repeat (3) @(negedge clk);
            check_output("bad_cmd_starts", starts_seen, 0);
            return;
        end

        check_output("first_start", 32'(eng_start), 1);
        check_output("busy_running", 32'(busy), 1);
        check_output("cmd_ready_running", 32'(cmd_ready), 0);

        exp_starts = (ar >= 0) ? ar + 1 : (rr >= 0) ? rr + 1 : nq;
        exp_err    = (dr >= 0) || (oo >= 0);
        budget     = nq * (nk * 3 + 12) + 50;
        ended      = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (batch_done === 1'b1 || reset_fired) begin
                ended = 1'b1;
                break;
            end
        end
        if (!ended) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL batch_timeout: got no batch_done in %0d cycles, required one", budget);
        end

        if (rr >= 0) begin
            check_output("rst_cmd_ready", 32'(cmd_ready), 1);
            check_output("rst_busy", 32'(busy), 0);
            check_output("rst_batch_done", 32'(batch_done), 0);
            check_output("rst_err", 32'(err), 0);
            check_output("rst_eng_start", 32'(eng_start), 0);
            check_output("rst_res_we", 32'(res_we), 0);
            check_output("rst_res_addr", 32'(res_addr), 0);
            check_output("rst_res_data", 32'(res_data), 0);
        end else begin
            check_output("err_at_done", 32'(err), 32'(exp_err));
            @(negedge clk);
            check_output("done_once", 32'(batch_done), 0);
            check_output("busy_after", 32'(busy), 0);
            check_output("cmd_ready_after", 32'(cmd_ready), 1);
        end
        repeat (3) @(negedge clk);
        #2;
        check_output("start_count", starts_seen, exp_starts);
        check_output("write_count", writes_seen, pushed_cnt);
        check_output("scoreboard_empty", sb.size(), 0);
        if (ar < 0 && rr < 0) begin
            check_output("write_total", writes_seen, nq * nk - ((dr >= 0) ? 1 : 0));
            if (dr < 0) begin
                missing = 0;
                for (int a = 0; a < nq * nk; a++) if (!hit[a]) missing++;
                check_output("addr_coverage_missing", missing, 0);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_output("reset_cmd_ready", 32'(cmd_ready), 1);
        check_output("reset_busy", 32'(busy), 0);
        check_output("reset_batch_done", 32'(batch_done), 0);
        check_output("reset_err", 32'(err), 0);
        check_output("reset_eng_start", 32'(eng_start), 0);
        check_output("reset_res_we", 32'(res_we), 0);
        check_output("reset_res_addr", 32'(res_addr), 0);
        check_output("reset_res_data", 32'(res_data), 0);
        tb_rst = 1'b0;
        @(negedge clk);

        //             nq   nk   drop oor abort@ rst@
        apply_stimulus(3,   64,  -1, -1, -1, 0,  -1, 0);
        apply_stimulus(1,   1,   -1, -1, -1, 0,  -1, 0);
        apply_stimulus(0,   5,   -1, -1, -1, 0,  -1, 0);
        apply_stimulus(2,   10,  -1, -1, -1, 0,  -1, 0);
        apply_stimulus(5,   0,   -1, -1, -1, 0,  -1, 0);
        apply_stimulus(129, 3,   -1, -1, -1, 0,  -1, 0);
        apply_stimulus(3,   129, -1, -1, -1, 0,  -1, 0);
        apply_stimulus(2,   64,  1,  -1, -1, 0,  -1, 0);
        apply_stimulus(2,   16,  -1, 0,  -1, 0,  -1, 0);
        apply_stimulus(4,   32,  -1, -1, 1,  10, -1, 0);
        apply_stimulus(3,   20,  -1, -1, -1, 0,  0,  5);
        apply_stimulus(2,   10,  -1, -1, -1, 0,  -1, 0);
        apply_stimulus(1,   128, -1, -1, -1, 0,  -1, 0);
        apply_stimulus(128, 1,   -1, -1, -1, 0,  -1, 0);
        for (int t = 0; t < 6; t++)
            apply_stimulus(int'($urandom_range(1, 5)), int'($urandom_range(1, 128)), -1, -1, -1, 0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
